// File: rtl/ps2_key_gen.sv
// PS/2 keyboard receiver: conditions the raw clock/data pins, deframes bytes and
// folds E0/F0/E1 prefixes into the toggle-strobed 11-bit ps2_key event word.
module ps2_key_gen #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 18000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_next;

  logic          clk_s1;
  logic          clk_s2;
  logic          data_s1;
  logic          data_s2;
  logic          clk_f;
  logic          data_f;
  logic          clk_f_d;
  logic [FW-1:0] clk_cnt;
  logic [FW-1:0] data_cnt;
  logic          fall;

  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          frame_good;
  logic          frame_bad;
  logic          timeout_hit;

  logic          ext;
  logic          brk;
  logic [2:0]    skip;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // The filtered level only follows after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_f   <= 1'b1;
      clk_cnt <= '0;
    end else if (clk_s2 == clk_f) begin
      clk_cnt <= '0;
    end else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
      clk_f   <= clk_s2;
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      data_f   <= 1'b1;
      data_cnt <= '0;
    end else if (data_s2 == data_f) begin
      data_cnt <= '0;
    end else if (data_cnt == FW'(FILTER_LEN - 1)) begin
      data_f   <= data_s2;
      data_cnt <= '0;
    end else begin
      data_cnt <= data_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_f_d <= 1'b1;
    end else begin
      clk_f_d <= clk_f;
    end
  end

  assign fall = clk_f_d & ~clk_f;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A stalled frame is abandoned before any further clock edge is considered.
  always_comb begin
    state_next  = state;
    frame_good  = 1'b0;
    frame_bad   = 1'b0;
    timeout_hit = 1'b0;
    if (state != IDLE && to_cnt == TW'(TIMEOUT)) begin
      timeout_hit = 1'b1;
      state_next  = IDLE;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!data_f) begin
            state_next = DATA;
          end
        end
        DATA: begin
          if (bit_cnt == 3'd7) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (data_f && (^{shift, par_bit})) begin
            frame_good = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset || state == IDLE || fall || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else if (fall && !timeout_hit) begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
        end
        DATA: begin
          shift   <= {data_f, shift[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: begin
          par_bit <= data_f;
        end
        default: begin
          bit_cnt <= bit_cnt;
        end
      endcase
    end
  end

  // Prefix tracking: skip swallows the seven bytes that follow E1 (Pause key).
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ps2_key <= '0;
      err     <= 1'b0;
      ext     <= 1'b0;
      brk     <= 1'b0;
      skip    <= '0;
    end else begin
      err <= frame_bad;
      if (frame_bad) begin
        ext  <= 1'b0;
        brk  <= 1'b0;
        skip <= '0;
      end else if (frame_good) begin
        if (skip != 3'd0) begin
          skip <= skip - 1'b1;
        end else if (shift == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift == 8'hF0) begin
          brk <= 1'b1;
        end else if (shift == 8'hE1) begin
          skip <= 3'd7;
        end else begin
          ps2_key <= {~ps2_key[10], ~brk, ext, shift};
          ext     <= 1'b0;
          brk     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_gen.sv
// Bench for ps2_key_gen: directed frames plus random traffic, scored against a
// byte-level model of the prefix/event rules through an expectation queue.
module tb_ps2_key_gen;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 400;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          is_err;
    logic [10:0] key;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_ext;
  bit          m_brk;
  int          m_skip;
  bit          m_toggle;
  logic [10:0] prev_key;

  always #5 clk_sys = ~clk_sys;

  ps2_key_gen #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .ps2_key (ps2_key),
    .err     (err)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [10:0] actual, input logic [10:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_ext    = 1'b0;
    m_brk    = 1'b0;
    m_skip   = 0;
    m_toggle = 1'b0;
  endtask

  // Keyboard protocol rules applied one received byte at a time.
  task automatic model_byte(input logic [7:0] b, input bit good);
    exp_t e;
    if (!good) begin
      e.is_err = 1'b1;
      e.key    = '0;
      exp_q.push_back(e);
      m_ext  = 1'b0;
      m_brk  = 1'b0;
      m_skip = 0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else begin
      m_toggle = !m_toggle;
      e.is_err = 1'b0;
      e.key    = {m_toggle, !m_brk, m_ext, b};
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // mode 0: good frame, 1: parity flipped, 2: stop bit low
  task automatic applyStimulus(input logic [7:0] b, input int mode, input int half);
    logic [10:0] bits;
    logic        par;
    logic        stop;
    par  = ~^b;
    if (mode == 1) par = ~par;
    stop = (mode == 2) ? 1'b0 : 1'b1;
    bits = {stop, par, b, 1'b0};
    model_byte(b, mode == 0);
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      tick(half);
      ps2_clk = 1'b0;
      tick(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(half + FILTER_LEN + 20);
  endtask

  task automatic sendPartial(input int nbits, input int half);
    logic [7:0] b;
    b = 8'($urandom);
    ps2_data = 1'b0;
    tick(half);
    ps2_clk = 1'b0;
    tick(half);
    ps2_clk = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = b[i];
      tick(half);
      ps2_clk = 1'b0;
      tick(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    model_reset();
    tick(2);
  endtask

  task automatic scoreCheck(input bit is_err, input logic [10:0] key);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("[TB] FAIL unexpected_output err=%0b key=%h required=none", is_err, key);
    end else begin
      e = exp_q.pop_front();
      if (e.is_err != is_err || (!is_err && e.key !== key)) begin
        n_errors++;
        $display("[TB] FAIL scoreboard actual err=%0b key=%h required err=%0b key=%h",
                 is_err, key, e.is_err, e.key);
      end
    end
  endtask

  // Every err pulse cycle and every ps2_key change consumes one expectation.
  always @(negedge clk_sys) begin
    if (reset) begin
      prev_key = ps2_key;
    end else begin
      if (err === 1'b1) scoreCheck(1'b1, ps2_key);
      if (ps2_key !== prev_key) scoreCheck(1'b0, ps2_key);
      prev_key = ps2_key;
    end
  end

  initial begin
    logic [7:0] pause_seq [0:7];
    logic [7:0] b;
    int         sel;
    int         mode;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    model_reset();
    tick(4);
    reset = 1'b0;
    tick(2);
    checkOutput("reset_key", ps2_key, 11'h000);
    checkOutput("reset_err", {10'd0, err}, 11'h000);

    $display("[TB] make and break codes");
    applyStimulus(8'h1C, 0, 20);
    checkOutput("make_1C", ps2_key, 11'h61C);
    applyStimulus(8'hF0, 0, 20);
    checkOutput("f0_no_change", ps2_key, 11'h61C);
    applyStimulus(8'h1C, 0, 20);
    checkOutput("break_1C", ps2_key, 11'h01C);

    $display("[TB] extended codes");
    applyStimulus(8'hE0, 0, 20);
    applyStimulus(8'h75, 0, 20);
    checkOutput("ext_make_75", ps2_key, 11'h775);
    applyStimulus(8'hE0, 0, 18);
    applyStimulus(8'hF0, 0, 18);
    applyStimulus(8'h75, 0, 18);
    checkOutput("ext_break_75", ps2_key, 11'h175);

    $display("[TB] parity error");
    applyStimulus(8'h29, 1, 20);
    checkOutput("parity_hold", ps2_key, 11'h175);
    applyStimulus(8'h29, 0, 20);
    checkOutput("after_parity_29", ps2_key, 11'h629);

    $display("[TB] timeout and mid-frame reset");
    sendPartial(4, 20);
    tick(TIMEOUT + 10);
    applyStimulus(8'h16, 0, 20);
    checkOutput("timeout_16", ps2_key, 11'h216);
    sendPartial(4, 20);
    tick(10);
    pulseReset();
    applyStimulus(8'h16, 0, 20);
    checkOutput("reset_mid_16", ps2_key, 11'h616);

    $display("[TB] pause sequence and glitch");
    pulseReset();
    for (int i = 0; i < 8; i++) applyStimulus(pause_seq[i], 0, 16);
    applyStimulus(8'h5A, 0, 16);
    checkOutput("pause_5A", ps2_key, 11'h65A);
    ps2_data = 1'b0;
    tick(20);
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(20);
    ps2_data = 1'b1;
    tick(40);
    checkOutput("glitch_hold", ps2_key, 11'h65A);
    applyStimulus(8'h1C, 0, 20);
    checkOutput("after_glitch_1C", ps2_key, 11'h21C);

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 15);
      if (sel <= 2)      b = 8'hE0;
      else if (sel <= 5) b = 8'hF0;
      else if (sel == 6) b = 8'hE1;
      else               b = 8'($urandom);
      sel  = $urandom_range(0, 9);
      mode = (sel == 0) ? 1 : ((sel == 1) ? 2 : 0);
      applyStimulus(b, mode, $urandom_range(14, 30));
    end

    tick(100);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
